// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the Hack CPU instruction-fetch stage.
//   fetch_state_t : fetch FSM state encoding (INIT, REQ, HOLD, DRAIN)
//   STALL_CNT_W   : width of the optional stall-cycle counter
package fetch_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
//   clk     in   clock, rising edge
//   reset_n in   asynchronous active-low clear
//   inc     in   count enable for this cycle
//   count   out  registered count value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: increments on inc, holds once saturated
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the Hack CPU.
// Drives the external PC controls, fetches from instruction ROM with a
// req/ack handshake and presents each instruction, tagged with its address,
// to decode on a valid/ready interface. Jumps from execute flush held or
// in-flight fetches.
//   clk, reset_n          clock / async active-low reset
//   pc                    current PC value (PC lives outside this block)
//   pc_load/pc_inc/pc_reset/pc_in   PC controls (combinational)
//   rom_req/rom_addr      ROM request (combinational), rom_ack/rom_data reply
//   jump/jump_addr        redirect from execute
//   inst_valid/inst_ready/inst/inst_pc   registered decode interface
//   stall_cycles          only when FETCH_STALL_CNT_EN is defined
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] pc,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_reset,
  output logic [width-1:0] pc_in,
  output logic             rom_req,
  output logic [width-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [width-1:0] rom_data,
  input  logic             jump,
  input  logic [width-1:0] jump_addr,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [width-1:0] inst,
  output logic [width-1:0] inst_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  fetch_state_t     state_r;
  fetch_state_t     state_next_s;
  logic             capture_s;
  logic             latch_drain_s;
  logic [width-1:0] inst_r;
  logic [width-1:0] inst_pc_r;
  logic             inst_valid_r;
  logic [width-1:0] drain_addr_r;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; jump outranks ack/ready everywhere except INIT
  always_comb begin
    state_next_s  = state_r;
    capture_s     = 1'b0;
    latch_drain_s = 1'b0;
    case (state_r)
      INIT: begin
        state_next_s = REQ;
      end
      REQ: begin
        if (jump) begin
          if (rom_ack) begin
            state_next_s = REQ;
          end else begin
            // Request stays outstanding; keep presenting the old address
            // while the PC is reloaded.
            state_next_s  = DRAIN;
            latch_drain_s = 1'b1;
          end
        end else if (rom_ack) begin
          state_next_s = HOLD;
          capture_s    = 1'b1;
        end else begin
          state_next_s = REQ;
        end
      end
      HOLD: begin
        if (jump || inst_ready) begin
          state_next_s = REQ;
        end else begin
          state_next_s = HOLD;
        end
      end
      DRAIN: begin
        if (rom_ack) begin
          state_next_s = REQ;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = INIT;
      end
    endcase
  end

  // Combinational PC and ROM controls
  always_comb begin
    pc_reset = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    rom_req  = 1'b0;
    rom_addr = pc;
    case (state_r)
      INIT: begin
        pc_reset = 1'b1;
      end
      REQ: begin
        rom_req = 1'b1;
        pc_load = jump;
        pc_inc  = rom_ack & ~jump;
      end
      HOLD: begin
        pc_load = jump;
      end
      DRAIN: begin
        rom_req  = 1'b1;
        rom_addr = drain_addr_r;
        pc_load  = jump;
      end
      default: begin
        pc_reset = 1'b0;
      end
    endcase
  end

  assign pc_in = jump_addr;

  // Decode-side registers and the address of an abandoned request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_r       <= '0;
      inst_pc_r    <= '0;
      inst_valid_r <= 1'b0;
      drain_addr_r <= '0;
    end else begin
      inst_valid_r <= (state_next_s == HOLD);
      if (capture_s) begin
        inst_r    <= rom_data;
        inst_pc_r <= pc;
      end else begin
        inst_r    <= inst_r;
        inst_pc_r <= inst_pc_r;
      end
      if (latch_drain_s) begin
        drain_addr_r <= pc;
      end else begin
        drain_addr_r <= drain_addr_r;
      end
    end
  end

  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign inst_valid = inst_valid_r;

`ifdef FETCH_STALL_CNT_EN
  logic stall_inc_s;

  // A stall is a ROM wait (REQ/DRAIN) or decode back-pressure (HOLD)
  always_comb begin
    stall_inc_s = 1'b0;
    case (state_r)
      REQ, DRAIN: stall_inc_s = ~rom_ack;
      HOLD:       stall_inc_s = ~inst_ready;
      default:    stall_inc_s = 1'b0;
    endcase
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc_s),
    .count   (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Provides a behavioural
// PC and a ROM with random latency, and checks the instruction stream against
// a program-flow model (next expected address, ROM contents, jump redirects).
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [15:0] pc;
  logic        pc_load, pc_inc, pc_reset;
  logic [15:0] pc_in;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        jump;
  logic [15:0] jump_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
  int          stall_exp;
  logic [31:0] s_mark;
`endif

  fetch_unit #(.width(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .pc_reset   (pc_reset),
    .pc_in      (pc_in),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM model state
  int lat_fixed;
  bit rom_busy;
  int rom_wait;

  // Program-flow model state
  logic [15:0] next_addr;
  bit          in_init;
  bit          prev_valid, prev_ready, prev_jump, prev_inc, prev_req, prev_ack;
  logic [15:0] prev_inst, prev_inst_pc, prev_rom_addr;
  logic [15:0] saved_addr, saved_inst;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0005;
    else if (a == 16'h0001) return 16'hEC10;
    else return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef FETCH_STALL_CNT_EN
  task automatic chk_c(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  // One clock cycle: ROM reply, checks at negedge, PC update after posedge.
  task automatic tick();
    logic        exp_load;
    logic [15:0] pc_nxt;
    if (reset_n && rom_req) begin
      if (!rom_busy) begin
        rom_busy = 1'b1;
        rom_wait = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end
      if (rom_wait == 0) begin
        rom_ack  = 1'b1;
        rom_data = rom_word(rom_addr);
        rom_busy = 1'b0;
      end else begin
        rom_ack  = 1'b0;
        rom_data = 16'($urandom);
        rom_wait--;
      end
    end else begin
      rom_ack  = 1'b0;
      rom_data = 16'($urandom);
      rom_busy = 1'b0;
    end
    #1;
    @(negedge clk);
    if (!reset_n) begin
      chk_b("rst_rom_req", rom_req, 1'b0);
      chk_b("rst_inst_valid", inst_valid, 1'b0);
      chk_w("rst_inst", inst, 16'h0000);
      chk_w("rst_inst_pc", inst_pc, 16'h0000);
      chk_b("rst_pc_reset", pc_reset, 1'b1);
      chk_b("rst_pc_load", pc_load, 1'b0);
      chk_b("rst_pc_inc", pc_inc, 1'b0);
`ifdef FETCH_STALL_CNT_EN
      chk_c("rst_stall", stall_cycles, 32'd0);
      stall_exp = 0;
`endif
      next_addr = 16'h0000;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_jump = 1'b0;
      prev_inc = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    end else begin
      exp_load = jump && !in_init;
      chk_b("pc_load", pc_load, exp_load);
      chk_w("pc_in", pc_in, jump_addr);
      chk_b("pc_reset", pc_reset, in_init);
      chk_b("pc_excl", (pc_load && pc_inc) || (pc_load && pc_reset) || (pc_inc && pc_reset), 1'b0);
      chk_b("inc_cause", pc_inc && !(rom_req && rom_ack && !jump), 1'b0);
      chk_b("hold_noreq", inst_valid && rom_req, 1'b0);
      if (in_init) chk_b("init_noreq", rom_req, 1'b0);
      if (prev_req && !prev_ack && rom_req) chk_w("rom_addr_stable", rom_addr, prev_rom_addr);
      if (prev_valid) chk_b("valid_seq", inst_valid, !(prev_ready || prev_jump));
      chk_b("inc_then_valid", inst_valid && !prev_valid, prev_inc);
      if (inst_valid && prev_valid) begin
        chk_w("inst_stable", inst, prev_inst);
        chk_w("inst_pc_stable", inst_pc, prev_inst_pc);
      end
      if (inst_valid && !prev_valid) begin
        chk_w("fetch_pc", inst_pc, next_addr);
        chk_w("fetch_data", inst, rom_word(inst_pc));
        next_addr = inst_pc + 16'h0001;
      end
      if (exp_load) next_addr = jump_addr;
`ifdef FETCH_STALL_CNT_EN
      chk_c("stall_cycles", stall_cycles, 32'(stall_exp));
      if ((rom_req && !rom_ack) || (inst_valid && !inst_ready)) stall_exp++;
`endif
      prev_valid = inst_valid; prev_ready = inst_ready; prev_jump = exp_load;
      prev_inc = pc_inc; prev_req = rom_req; prev_ack = rom_ack;
      prev_rom_addr = rom_addr; prev_inst = inst; prev_inst_pc = inst_pc;
    end
    pc_nxt = pc_reset ? 16'h0000 : pc_load ? pc_in : pc_inc ? pc + 16'h0001 : pc;
    in_init = 1'b0;
    @(posedge clk);
    #1 pc = pc_nxt;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; pc = 16'h1234; jump = 1'b1; jump_addr = 16'h00FF;
    inst_ready = 1'b1; rom_ack = 1'b0; rom_data = 16'h0000;
    lat_fixed = 0; rom_busy = 1'b0; rom_wait = 0; in_init = 1'b0;
    next_addr = 16'h0000;
`ifdef FETCH_STALL_CNT_EN
    stall_exp = 0;
`endif
    @(posedge clk); #2;

    // Reset held with jump asserted, then release; jump is ignored in INIT
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1; in_init = 1'b1;
    tick();
    jump = 1'b0;
    chk_b("first_req", rom_req, 1'b1);
    chk_w("first_addr", rom_addr, 16'h0000);

    // Zero-wait ROM: two instructions, two cycles apart
    tick();
    chk_b("z0_valid", inst_valid, 1'b1);
    chk_w("z0_inst", inst, 16'h0005);
    chk_w("z0_pc", inst_pc, 16'h0000);
    tick(); tick();
    chk_b("z1_valid", inst_valid, 1'b1);
    chk_w("z1_inst", inst, 16'hEC10);
    chk_w("z1_pc", inst_pc, 16'h0001);

    // ROM acks on the third request cycle: four fetches
    lat_fixed = 2;
    tick();
`ifdef FETCH_STALL_CNT_EN
    s_mark = stall_cycles;
`endif
    for (int i = 0; i < 15; i++) tick();
    chk_b("late_valid", inst_valid, 1'b1);
    chk_w("late_pc", inst_pc, 16'h0005);
`ifdef FETCH_STALL_CNT_EN
    chk_c("late_stall", stall_cycles, s_mark + 32'd8);
    s_mark = stall_cycles;
`endif

    // Decode back-pressure for four cycles
    inst_ready = 1'b0;
    saved_inst = inst;
    for (int i = 0; i < 4; i++) tick();
    chk_b("bp_valid", inst_valid, 1'b1);
    chk_w("bp_inst", inst, saved_inst);
    chk_w("bp_pc", inst_pc, 16'h0005);
`ifdef FETCH_STALL_CNT_EN
    chk_c("bp_stall", stall_cycles, s_mark + 32'd4);
`endif
    inst_ready = 1'b1;
    tick();

    // Jump while holding an instruction
    lat_fixed = 0; inst_ready = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    chk_b("hold_reached", inst_valid, 1'b1);
    jump = 1'b1; jump_addr = 16'h0040;
    tick();
    jump = 1'b0;
    chk_b("hj_flush", inst_valid, 1'b0);
    chk_b("hj_req", rom_req, 1'b1);
    chk_w("hj_addr", rom_addr, 16'h0040);

    // Jump in REQ one cycle before a late ack
    inst_ready = 1'b1; lat_fixed = 2;
    saved_addr = rom_addr;
    tick();
    jump = 1'b1; jump_addr = 16'h0100;
    tick();
    jump = 1'b0;
    chk_b("drain_req", rom_req, 1'b1);
    chk_w("drain_addr", rom_addr, saved_addr);
    tick();
    chk_b("drain_discard", inst_valid, 1'b0);
    chk_w("redirect_addr", rom_addr, 16'h0100);
    lat_fixed = 0;
    tick();
    chk_b("redirect_valid", inst_valid, 1'b1);
    chk_w("redirect_pc", inst_pc, 16'h0100);
    chk_w("redirect_inst", inst, rom_word(16'h0100));

    // Reset asserted while draining
    lat_fixed = 3;
    tick(); tick();
    jump = 1'b1; jump_addr = 16'h0200;
    tick();
    jump = 1'b0;
    chk_w("drain2_addr", rom_addr, 16'h0101);
    #1 reset_n = 1'b0;
    #1;
    chk_b("async_rom_req", rom_req, 1'b0);
    chk_b("async_valid", inst_valid, 1'b0);
    chk_b("async_pc_reset", pc_reset, 1'b1);
    tick(); tick();
    reset_n = 1'b1; in_init = 1'b1;
    tick();
    chk_b("restart_req", rom_req, 1'b1);
    chk_w("restart_addr", rom_addr, 16'h0000);

    // Randomised traffic: latency, back-pressure and jumps
    lat_fixed = -1;
    for (int i = 0; i < 1500; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      jump       = ($urandom_range(0, 15) == 0);
      jump_addr  = 16'($urandom);
      tick();
    end
    jump = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the Hack CPU, sitting between the program counter and instruction decode. It drives the PC's `load`/`inc`/`reset`/`in` controls, issues requests to instruction ROM with a req/ack handshake, and holds each fetched instruction, tagged with its address, on a valid/ready interface to decode. Jump redirects from execute flush held or in-flight fetches.

## Interface
- `width`, default 16: instruction and address width.

- `clk`  in  1  single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc`  in  width  current PC register value.
- `pc_load`  out  width-independent 1  PC load select.
- `pc_inc`  out  1  PC increment select.
- `pc_reset`  out  1  PC synchronous clear.
- `pc_in`  out  width  PC load value; equals `jump_addr`.
- `rom_req`  out  1  ROM request.
- `rom_addr`  out  width  ROM address.
- `rom_ack`  in  1  ROM data valid; one-cycle pulse.
- `rom_data`  in  width  ROM instruction word.
- `jump`  in  1  redirect pulse from execute.
- `jump_addr`  in  width  redirect target.
- `inst_valid`  out  1  instruction held for decode.
- `inst_ready`  in  1  decode accepts.
- `inst`  out  width  held instruction.
- `inst_pc`  out  width  address of `inst`.
- `stall_cycles`  out  32  present only with `FETCH_STALL_CNT_EN`.

## Operation
- States: INIT, REQ, HOLD, DRAIN.
- Reset (async): state INIT. `rom_req`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `pc_load`=0, `pc_inc`=0, `pc_reset`=1, `stall_cycles`=0. `drain_addr`=0.
- INIT: `pc_reset`=1 for exactly one cycle after reset release; next state REQ. `jump` is ignored in INIT.
- REQ: `rom_req`=1, `rom_addr`=`pc`.
  - On `rom_ack`: capture `rom_data`→`inst`, `pc`→`inst_pc`; assert `pc_inc` in the same cycle; next state HOLD.
- HOLD: `inst_valid`=1; `rom_req`=0.
  - On `inst_ready`: handshake completes; next state REQ.
- DRAIN: `rom_req`=1, `rom_addr`=`drain_addr`.
  - On `rom_ack`: data discarded; next state REQ.
- `jump` has priority over every other event in REQ, HOLD and DRAIN.
  - It asserts `pc_load`=1, `pc_inc`=0, and `pc_in`=`jump_addr` combinationally.
  - REQ with `rom_ack`: data discarded; next state REQ.
  - REQ without `rom_ack`: latch `pc` into `drain_addr`; next state DRAIN. The ROM address never changes while a request is outstanding.
  - HOLD: held instruction is flushed (`inst_valid`=0 next cycle); next state REQ. If `inst_ready` is also high, decode consumed the instruction; the redirect still applies.
  - DRAIN: PC is reloaded; stay in DRAIN unless `rom_ack`, in which case the next state is REQ.
- Control outputs are mutually exclusive: at most one of `pc_load`, `pc_inc`, `pc_reset` is high in any cycle.
- Address arithmetic is performed by the PC and wraps modulo 2^width. The block does no arithmetic on addresses.

## Timing
- Zero-wait ROM (`rom_ack` in the first REQ cycle): 2 cycles per instruction (REQ, HOLD).
- The instruction is valid in the cycle after `rom_ack`.
- Earliest first `rom_req`: second cycle after `reset_n` rises.
- `inst`/`inst_pc` are registered and stable while `inst_valid`=1.
- `rom_*` and `pc_*` outputs are combinational from state and inputs.
- Reset mid-request drops `rom_req` immediately. The ROM shares `reset_n` and abandons the request.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_cycles` port exists.
  - Counts cycles in REQ/DRAIN without `rom_ack`, plus cycles in HOLD without `inst_ready`.
  - Saturates at 2^32−1 and is cleared only by reset.
- `FETCH_STALL_CNT_EN` undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg`: state encoding constants (INIT=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3) and the counter width constant (32).
- One natural sub-module, `sat_counter`: parameterised saturating counter, instantiated only under `FETCH_STALL_CNT_EN`.
- The PC is instantiated alongside, not inside, this block.

## Test plan
- Reset release, zero-wait ROM, ROM[0]=16'h0005, ROM[1]=16'hEC10, `inst_ready`=1:
  - `pc_reset` pulses once.
  - `inst`=0005/`inst_pc`=0, then `inst`=EC10/`inst_pc`=1, each 2 cycles apart.
- ROM acks 3 cycles late:
  - `rom_addr` stays constant across the wait.
  - `stall_cycles`=2 per fetch when enabled.
- HOLD with `inst_ready`=0 for 4 cycles:
  - `inst`/`inst_pc` are unchanged.
  - No `rom_req` is issued.
  - `pc_inc` fires exactly once per fetch.
- `jump`=1, `jump_addr`=16'h0040 in HOLD:
  - `pc_load`=1 and `pc_in`=0040.
  - `inst_valid` drops next cycle.
  - Next `rom_addr`=0040.
- `jump` in REQ 1 cycle before a late `rom_ack`:
  - DRAIN holds the old address until ack, and that data is never presented.
  - Next fetch is from `jump_addr`.
- `reset_n` low mid-DRAIN:
  - `rom_req`=0 and `inst_valid`=0 asynchronously.
  - Restart goes through INIT with one `pc_reset` pulse.
